// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM transmit chain: default dimensions,
// frame-sequencer state encoding, {real, imag} packing and the
// cyclic-prefix address mapping.
package ofdm_pkg;

  localparam int OFDM_N            = 8;
  localparam int OFDM_CP           = 4;
  localparam int OFDM_W            = 16;
  localparam int OFDM_IDX_W        = 3;
  localparam int OFDM_IFFT_TIMEOUT = 64;

  // State encoding of the frame sequencer
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_RUN_IFFT = 3'd2;
  localparam logic [2:0] ST_TX_ADDR  = 3'd3;
  localparam logic [2:0] ST_TX_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    LOAD     = ST_LOAD,
    RUN_IFFT = ST_RUN_IFFT,
    TX_ADDR  = ST_TX_ADDR,
    TX_HOLD  = ST_TX_HOLD
  } state_t;

  // Word slots inside a packed complex sample: {real, imag}.
  // A W-bit component sits at bits [slot*W +: W].
  localparam int RE_SLOT = 1;
  localparam int IM_SLOT = 0;

  // Sequence index -> IFFT output address: the last cp samples first,
  // then the whole block from address 0.
  function automatic int cp_addr(input int seq, input int n, input int cp);
    return (seq < cp) ? (n - cp + seq) : (seq - cp);
  endfunction

endpackage

// File: rtl/ofdm_frame_ctrl_if.sv
// Bundle of the mapper, IFFT and DAC handshake signals around the frame
// sequencer. master = sequencer side, slave = the surrounding datapath.
interface ofdm_frame_ctrl_if
  import ofdm_pkg::*;
#(
  parameter int W     = OFDM_W,
  parameter int IDX_W = OFDM_IDX_W
);
  logic               gen_en;
  logic               qam_valid;
  logic               qam_last;
  logic               map_ready;
  logic               ifft_start;
  logic               ifft_done;
  logic [IDX_W-1:0]   ifft_rd_addr;
  logic [2*W-1:0]     ifft_rd_data;
  logic [W-1:0]       dac_data;
  logic               dac_valid;
  logic               dac_ready;

  modport master (
    output gen_en, map_ready, ifft_start, ifft_rd_addr, dac_data, dac_valid,
    input  qam_valid, qam_last, ifft_done, ifft_rd_data, dac_ready
  );

  modport slave (
    input  gen_en, map_ready, ifft_start, ifft_rd_addr, dac_data, dac_valid,
    output qam_valid, qam_last, ifft_done, ifft_rd_data, dac_ready
  );
endinterface

// File: rtl/ofdm_cp_addr_gen.sv
// Sample sequence counter for the transmit phase. Produces the registered
// IFFT read address in cyclic-prefix order and flags the final sample.
module ofdm_cp_addr_gen
  import ofdm_pkg::*;
#(
  parameter int N     = OFDM_N,
  parameter int CP    = OFDM_CP,
  parameter int IDX_W = OFDM_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  output logic             o_last,
  output logic [IDX_W-1:0] o_addr
);
  localparam int SEQ_W    = $clog2(N + CP);
  localparam int LAST_SEQ = N + CP - 1;

  logic [SEQ_W-1:0] r_seq;
  logic [IDX_W-1:0] r_addr;
  int               w_seq_inc;

  assign w_seq_inc = int'(r_seq) + 1;

  // Address is computed for the next seq so it is a plain register at the output
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seq  <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_seq  <= '0;
      r_addr <= IDX_W'(cp_addr(0, N, CP));
    end else if (i_step) begin
      r_seq  <= SEQ_W'(w_seq_inc);
      r_addr <= IDX_W'(cp_addr(w_seq_inc, N, CP));
    end
  end

  assign o_last = (int'(r_seq) == LAST_SEQ);
  assign o_addr = r_addr;

endmodule

// File: rtl/ofdm_frame_ctrl.sv
// Frame sequencer: gathers N mapped symbols, runs the IFFT, then streams
// the cyclic-prefixed time-domain block to the DAC over valid/ready.
module ofdm_frame_ctrl
  import ofdm_pkg::*;
#(
  parameter int N            = OFDM_N,
  parameter int CP           = OFDM_CP,
  parameter int W            = OFDM_W,
  parameter int IDX_W        = OFDM_IDX_W,
  parameter int IFFT_TIMEOUT = OFDM_IFFT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  ofdm_frame_ctrl_if.master bus,
  output logic [15:0]       o_frame_cnt,
  output logic              o_sync_err,
  output logic              o_ifft_err,
  output logic              o_busy
);
  localparam int TO_W = $clog2(IFFT_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_sym_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_ifft_start;
  logic             r_hold_first;
  logic [W-1:0]     r_dac_hold;
  logic [15:0]      r_frame_cnt;
  logic             r_sync_err;
  logic             r_ifft_err;

  logic             w_beat;
  logic             w_sym_inc;
  logic             w_sym_clr;
  logic             w_sync_set;
  logic             w_ifft_set;
  logic             w_start;
  logic             w_seq_load;
  logic             w_seq_step;
  logic             w_seq_last;
  logic             w_frame_inc;
  logic [IDX_W-1:0] w_rd_addr;
  logic [W-1:0]     w_rd_real;
  logic [W-1:0]     w_unused_imag;

  assign w_rd_real     = bus.ifft_rd_data[RE_SLOT*W +: W];
  assign w_unused_imag = bus.ifft_rd_data[IM_SLOT*W +: W];
  assign w_beat        = bus.qam_valid && (r_state == LOAD);

  ofdm_cp_addr_gen #(
    .N     (N),
    .CP    (CP),
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_seq_load),
    .i_step (w_seq_step),
    .o_last (w_seq_last),
    .o_addr (w_rd_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and one-cycle strobes for the datapath registers
  always_comb begin
    w_state_next = r_state;
    w_sym_inc    = 1'b0;
    w_sym_clr    = 1'b0;
    w_sync_set   = 1'b0;
    w_ifft_set   = 1'b0;
    w_start      = 1'b0;
    w_seq_load   = 1'b0;
    w_seq_step   = 1'b0;
    w_frame_inc  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sym_clr = 1'b1;
        if (i_enable) w_state_next = LOAD;
      end
      LOAD: begin
        if (w_beat) begin
          if (r_sym_cnt == IDX_W'(N - 1)) begin
            // A full frame goes on even when qam_last is missing; the flag records it
            w_sym_clr    = 1'b1;
            w_start      = 1'b1;
            w_sync_set   = !bus.qam_last;
            w_state_next = RUN_IFFT;
          end else if (bus.qam_last) begin
            // Early last: drop the partial frame and restart the count
            w_sym_clr  = 1'b1;
            w_sync_set = 1'b1;
          end else begin
            w_sym_inc = 1'b1;
          end
        end
      end
      RUN_IFFT: begin
        if (bus.ifft_done) begin
          w_seq_load   = 1'b1;
          w_state_next = TX_ADDR;
        end else if (r_to_cnt == TO_W'(IFFT_TIMEOUT - 1)) begin
          w_ifft_set   = 1'b1;
          w_state_next = IDLE;
        end
      end
      TX_ADDR: begin
        w_state_next = TX_HOLD;
      end
      TX_HOLD: begin
        if (bus.dac_ready) begin
          if (w_seq_last) begin
            w_frame_inc  = 1'b1;
            w_state_next = i_enable ? LOAD : IDLE;
          end else begin
            w_seq_step   = 1'b1;
            w_state_next = TX_ADDR;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Symbol/timeout counters, sample hold register, frame counter and sticky errors
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sym_cnt    <= '0;
      r_to_cnt     <= '0;
      r_ifft_start <= 1'b0;
      r_hold_first <= 1'b0;
      r_dac_hold   <= '0;
      r_frame_cnt  <= '0;
      r_sync_err   <= 1'b0;
      r_ifft_err   <= 1'b0;
    end else begin
      r_ifft_start <= w_start;
      // First TX_HOLD cycle is the one right after TX_ADDR; the read data arrives then
      r_hold_first <= (r_state == TX_ADDR);
      if (r_hold_first) r_dac_hold <= w_rd_real;
      if (w_sym_clr)      r_sym_cnt <= '0;
      else if (w_sym_inc) r_sym_cnt <= r_sym_cnt + 1'b1;
      if (r_state == RUN_IFFT) r_to_cnt <= r_to_cnt + 1'b1;
      else                     r_to_cnt <= '0;
      if (w_sync_set)  r_sync_err  <= 1'b1;
      if (w_ifft_set)  r_ifft_err  <= 1'b1;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.gen_en       = (r_state == LOAD);
  assign bus.map_ready    = (r_state == LOAD);
  assign bus.ifft_start   = r_ifft_start;
  assign bus.ifft_rd_addr = w_rd_addr;
  assign bus.dac_valid    = (r_state == TX_HOLD);
  // Read data passes straight through on the first hold cycle, then the held copy
  assign bus.dac_data     = r_hold_first ? w_rd_real : r_dac_hold;

  assign o_frame_cnt = r_frame_cnt;
  assign o_sync_err  = r_sync_err;
  assign o_ifft_err  = r_ifft_err;
  assign o_busy      = (r_state != IDLE);

endmodule
